// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared FSM state encodings and default parameter constants for key_repeat_ctrl
package key_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2,
      LOCK   = 2'd3
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 50000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;
   localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser plus counting debouncer for one active-low raw key
module key_debounce
   import key_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   // Count of consecutive samples that disagree with level; never exceeds DEBOUNCE_CYCLES.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous key into the clk domain; released (1) out of reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level once DEBOUNCE_CYCLES consecutive differing samples have been counted;
   // any sample matching the current level restarts the count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         level <= 1'b1;
         cnt   <= '0;
      end else if (cnt >= CNT_LAST) begin
         level <= ~level;
         cnt   <= '0;
      end else if (sync2 != level) begin
         cnt   <= cnt + 1'b1;
      end else begin
         cnt   <= '0;
      end
   end

endmodule

// File: rtl/key_repeat_ctrl.sv
// rtl/key_repeat_ctrl.sv - up/down step pulse generator with debounce, lockout and optional auto-repeat (KEY_REPEAT_CTRL_AUTOREPEAT_EN)
module key_repeat_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic button_up,
   input  logic button_down,
   output logic enable,
   output logic up_down,
   output logic busy
);

   logic   level_up;
   logic   level_down;
   logic   up_p;
   logic   dn_p;
   logic   held_p;
   logic   other_p;
   logic   held_up;
   state_t state;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_up (
      .clk   (clk),
      .reset (reset),
      .raw   (button_up),
      .level (level_up)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_down (
      .clk   (clk),
      .reset (reset),
      .raw   (button_down),
      .level (level_down)
   );

   assign up_p    = ~level_up;
   assign dn_p    = ~level_down;
   assign held_p  = held_up ? up_p : dn_p;
   assign other_p = held_up ? dn_p : up_p;

`ifdef KEY_REPEAT_CTRL_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rpt_cnt;
`else
   // Repeat timing is unused in this build; the scope below only appears for an illegal setting.
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_cfg
   end
`endif

   // Step FSM: one pulse per accepted press, repeats while held, lockout when both keys are down.
   // A pending pulse waits a cycle if enable is still high so pulses never touch.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         held_up <= 1'b0;
         enable  <= 1'b0;
         up_down <= 1'b0;
         busy    <= 1'b0;
`ifdef KEY_REPEAT_CTRL_AUTOREPEAT_EN
         rpt_cnt <= '0;
`endif
      end else begin
         enable  <= 1'b0;
         up_down <= 1'b0;
         busy    <= up_p | dn_p;
         case (state)
            IDLE: begin
               if (up_p && dn_p) begin
                  state <= LOCK;
               end else if ((up_p || dn_p) && !enable) begin
                  enable  <= 1'b1;
                  up_down <= up_p;
                  held_up <= up_p;
                  state   <= DELAY;
`ifdef KEY_REPEAT_CTRL_AUTOREPEAT_EN
                  rpt_cnt <= '0;
`endif
               end
            end
            DELAY: begin
               if (!held_p) begin
                  state <= IDLE;
               end else if (other_p) begin
                  state <= LOCK;
               end
`ifdef KEY_REPEAT_CTRL_AUTOREPEAT_EN
               else if (rpt_cnt >= DELAY_LAST) begin
                  if (!enable) begin
                     enable  <= 1'b1;
                     up_down <= held_up;
                     rpt_cnt <= '0;
                     state   <= REPEAT;
                  end
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
`endif
            end
`ifdef KEY_REPEAT_CTRL_AUTOREPEAT_EN
            REPEAT: begin
               if (!held_p) begin
                  state <= IDLE;
               end else if (other_p) begin
                  state <= LOCK;
               end else if (rpt_cnt >= PERIOD_LAST) begin
                  if (!enable) begin
                     enable  <= 1'b1;
                     up_down <= held_up;
                     rpt_cnt <= '0;
                  end
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
            end
`endif
            LOCK: begin
               if (!up_p && !dn_p) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb/tb_key_repeat_ctrl.sv - scoreboard bench for key_repeat_ctrl (follows KEY_REPEAT_CTRL_AUTOREPEAT_EN)
module tb_key_repeat_ctrl;
   import key_ctrl_pkg::*;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;
   localparam int CW = 8;

   logic clk         = 1'b0;
   logic reset       = 1'b0;
   logic button_up   = 1'b1;
   logic button_down = 1'b1;
   logic enable;
   logic up_down;
   logic busy;

   key_repeat_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_W           (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .button_up   (button_up),
      .button_down (button_down),
      .enable      (enable),
      .up_down     (up_down),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Rising-edge count; at a falling edge cyc equals the number of the edge just taken.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   at;
      logic ud;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_vec   = 0;
   int   n_err   = 0;
   logic prev_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int at, input logic ud);
      exp_t e;
      e.at = at;
      e.ud = ud;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pop an expectation for every enable pulse; flag missed, unexpected and adjacent pulses.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         n_vec++;
         n_err++;
         $display("FAIL missed_pulse: got no enable, expected enable at edge %0d", exp_q[0].at);
         void'(exp_q.pop_front());
      end
      if (enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: got enable at edge %0d, expected none", cyc);
         end else begin
            cur = exp_q.pop_front();
            check("pulse_edge", cyc, cur.at);
            check("pulse_dir", {31'd0, up_down}, {31'd0, cur.ud});
         end
      end else if (up_down !== 1'b0) begin
         n_err++;
         $display("FAIL up_down_idle: got %b, expected 0 at edge %0d", up_down, cyc);
      end
      if (prev_en === 1'b1 && enable === 1'b1) begin
         n_err++;
         $display("FAIL back_to_back: got enable on edges %0d and %0d, expected gap", cyc - 1, cyc);
      end
      prev_en = enable;
   end

   int e0;
   int r;

   initial begin
      step(3);
      check("reset_enable", {31'd0, enable}, 0);
      check("reset_up_down", {31'd0, up_down}, 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b1;
      step(2);

      // Short bounce: 3 low samples never reach the debounce count.
      button_up = 1'b0;
      step(3);
      button_up = 1'b1;
      step(15);
      check("bounce_busy", {31'd0, busy}, 0);

      // Single down press of 8 samples: one pulse 7 edges after the first low sample.
      button_down = 1'b0;
      e0 = cyc + 1;
      push(e0 + 7, 1'b0);
      step(8);
      check("press_busy", {31'd0, busy}, 1);
      button_down = 1'b1;
      step(20);
      check("down_release_busy", {31'd0, busy}, 0);
      check("down_release_state", 32'(dut.state), 32'(IDLE));

      // Up held 30 samples: first pulse, delay, then period repeats; release wins at e0+37.
      button_up = 1'b0;
      e0 = cyc + 1;
      push(e0 + 7, 1'b1);
`ifdef KEY_REPEAT_CTRL_AUTOREPEAT_EN
      push(e0 + 17, 1'b1);
      push(e0 + 22, 1'b1);
      push(e0 + 27, 1'b1);
      push(e0 + 32, 1'b1);
`endif
      step(30);
      button_up = 1'b1;
      step(25);
      check("hold_release_state", 32'(dut.state), 32'(IDLE));

      // Both keys together: lockout, no pulses, back to idle once both released.
      button_up   = 1'b0;
      button_down = 1'b0;
      step(10);
      check("lock_state", 32'(dut.state), 32'(LOCK));
      check("lock_busy", {31'd0, busy}, 1);
      step(10);
      button_up   = 1'b1;
      button_down = 1'b1;
      step(20);
      check("unlock_state", 32'(dut.state), 32'(IDLE));
      button_up = 1'b0;
      e0 = cyc + 1;
      push(e0 + 7, 1'b1);
      step(8);
      button_up = 1'b1;
      step(20);

      // Reset while repeating with the key still held: outputs clear, full debounce afterwards.
      button_up = 1'b0;
      e0 = cyc + 1;
      push(e0 + 7, 1'b1);
`ifdef KEY_REPEAT_CTRL_AUTOREPEAT_EN
      push(e0 + 17, 1'b1);
`endif
      step(20);
      reset = 1'b0;
      step(1);
      check("midreset_enable", {31'd0, enable}, 0);
      check("midreset_up_down", {31'd0, up_down}, 0);
      check("midreset_busy", {31'd0, busy}, 0);
      check("midreset_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b1;
      r = cyc + 1;
      push(r + 7, 1'b1);
      step(8);
      button_up = 1'b1;
      step(25);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
